// File: rtl/gpr_wb_pkg.sv
// Shared widths and the load tag record for the GPR writeback unit.
package gpr_wb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << REG_AW;
  localparam logic [REG_AW-1:0] RA_REG = 5'd31;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              kill;
  } wb_tag_t;
endpackage

// File: rtl/gpr_writeback_unit_tag_fifo.sv
// wb_tag_fifo: in-order circular buffer of outstanding load destinations.
// Supports marking every live entry with a given dst as killed (WAW by a
// younger ALU write) and produces the pending-load scoreboard mask.
module wb_tag_fifo
  import gpr_wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [REG_AW-1:0] push_dst,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_dst,
  output logic              full,
  output logic              empty,
  output wb_tag_t           head,
  output logic [NREGS-1:0]  pend_mask
);
  localparam int PW = $clog2(LD_DEPTH);

  wb_tag_t [LD_DEPTH-1:0] mem_q, mem_d;
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count;
  logic [LD_DEPTH-1:0] valid;
  logic do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (PW+1)'(LD_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // An entry is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < LD_DEPTH; i++) begin : g_valid
    logic [PW-1:0] off;
    assign off      = PW'(i) - rd_ptr_q[PW-1:0];
    assign valid[i] = ({1'b0, off} < count);
  end

  // Kill matching live entries; the slot being pushed is not live yet, so a
  // same-cycle load to the same register survives (it is the younger one).
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < LD_DEPTH; i++)
      if (kill_en && valid[i] && mem_q[i].dst == kill_dst) mem_d[i].kill = 1'b1;
    if (do_push) mem_d[wr_ptr_q[PW-1:0]] = '{dst: push_dst, kill: 1'b0};
  end

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (PW+1)'(do_pop);
  end

  // Scoreboard mask from live, unkilled entries (head still counts while popping).
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LD_DEPTH; i++)
      if (valid[i] && !mem_q[i].kill) pend_mask[mem_q[i].dst] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/gpr_writeback_unit.sv
// gpr_writeback_unit: arbitrates ALU results and in-order load returns onto
// the single GPR write port. Load returns win; an ALU result that loses is
// parked in a one-entry skid and written on the next free cycle.
// Optional WB_STATS_EN adds saturating stall / killed-load counters.
module gpr_writeback_unit
  import gpr_wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_dst,
  input  logic              alu_jal,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [REG_AW-1:0] ld_dst,
  output logic              ld_ready,
  input  logic              ld_rvalid,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  pend_mask,
`ifdef WB_STATS_EN
  output logic [15:0]       stat_alu_stall,
  output logic [15:0]       stat_ld_kill,
`endif
  output logic              ld_err
);
  logic              skid_valid_q, skid_valid_d;
  logic [REG_AW-1:0] skid_dst_q, skid_dst_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              ld_err_q, ld_err_d;
  logic              fifo_full, fifo_empty, alu_acc, ld_pop;
  logic [REG_AW-1:0] alu_eff_dst;
  wb_tag_t           head;

  assign alu_ready   = !skid_valid_q;
  assign alu_acc     = alu_valid && alu_ready;
  assign alu_eff_dst = alu_jal ? RA_REG : alu_dst;
  assign ld_ready    = !fifo_full;
  assign ld_pop      = ld_rvalid && !fifo_empty;

  wb_tag_fifo #(.LD_DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (ld_issue && ld_ready),
    .push_dst (ld_dst),
    .pop      (ld_pop),
    .kill_en  (alu_acc),
    .kill_dst (alu_eff_dst),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head),
    .pend_mask(pend_mask)
  );

  // Write arbiter: load return > skid > fresh ALU; r0 and killed loads are
  // consumed without asserting wr_en.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_dst_d   = skid_dst_q;
    skid_data_d  = skid_data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (ld_pop) begin
      if (!head.kill && head.dst != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = head.dst;
        wr_data_d = ld_rdata;
      end
      if (alu_acc) begin
        skid_valid_d = 1'b1;
        skid_dst_d   = alu_eff_dst;
        skid_data_d  = alu_data;
      end
    end else if (skid_valid_q) begin
      skid_valid_d = 1'b0;
      if (skid_dst_q != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = skid_dst_q;
        wr_data_d = skid_data_q;
      end
    end else if (alu_acc && alu_eff_dst != '0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_eff_dst;
      wr_data_d = alu_data;
    end
  end

  // Sticky error on a return with no outstanding tag.
  always_comb ld_err_d = ld_err_q || (ld_rvalid && fifo_empty);

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_dst_q   <= '0;
      skid_data_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      ld_err_q     <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_dst_q   <= skid_dst_d;
      skid_data_q  <= skid_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      ld_err_q     <= ld_err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign ld_err  = ld_err_q;

`ifdef WB_STATS_EN
  logic [15:0] stall_q, stall_d, kill_q, kill_d;

  // Saturating counters: stalled ALU offers and killed load pops.
  always_comb begin
    stall_d = stall_q;
    kill_d  = kill_q;
    if (alu_valid && !alu_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    if (ld_pop && head.kill && kill_q != 16'hFFFF)      kill_d  = kill_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      kill_q  <= '0;
    end else begin
      stall_q <= stall_d;
      kill_q  <= kill_d;
    end
  end

  assign stat_alu_stall = stall_q;
  assign stat_ld_kill   = kill_q;
`endif
endmodule

// File: tb/tb_gpr_writeback_unit.sv
// Bench for gpr_writeback_unit: table-driven ALU vectors plus hand-written
// load/skid/kill/error sequences; register writes are checked against a
// queue of expected {addr,data} pushed as stimulus is driven.
module tb_gpr_writeback_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, alu_jal;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        ld_issue, ld_ready, ld_rvalid;
  logic [4:0]  ld_dst;
  logic [31:0] ld_rdata;
  logic        wr_en, ld_err;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;

  gpr_writeback_unit #(.LD_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst),
    .alu_jal(alu_jal), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_dst(ld_dst), .ld_ready(ld_ready),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_mask(pend_mask), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.a});
        chk("wr_data", wr_data, e.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_jal = 0; alu_dst = 0; alu_data = 0;
    ld_issue = 0; ld_dst = 0; ld_rvalid = 0; ld_rdata = 0;
  endtask

  task automatic expw(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  typedef struct {
    logic [4:0]  dst;
    logic        jal;
    logic [31:0] data;
    logic        exp_en;
    logic [4:0]  exp_addr;
  } alu_vec_t;

  alu_vec_t vecs[6];

  initial begin
    vecs[0] = '{5'd5,  1'b0, 32'h0000_1234, 1'b1, 5'd5};
    vecs[1] = '{5'd7,  1'b1, 32'h0000_ABCD, 1'b1, 5'd31};
    vecs[2] = '{5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0, 5'd0};
    vecs[3] = '{5'd0,  1'b1, 32'h0000_0001, 1'b1, 5'd31};
    vecs[4] = '{5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 5'd31};
    vecs[5] = '{5'd1,  1'b0, 32'h0000_0000, 1'b1, 5'd1};

    idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    cyc();
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_ld_err", {31'd0, ld_err}, 0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 1);
    chk("rst_alu_ready", {31'd0, alu_ready}, 1);

    // Single ALU writes, one cycle latency.
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_dst = vecs[i].dst; alu_jal = vecs[i].jal; alu_data = vecs[i].data;
      if (vecs[i].exp_en) expw(vecs[i].exp_addr, vecs[i].data);
      chk("alu_ready_vec", {31'd0, alu_ready}, 1);
      cyc();
      idle();
      chk("vec_wr_en", {31'd0, wr_en}, {31'd0, vecs[i].exp_en});
      cyc();
      chk("vec_wr_en_drop", {31'd0, wr_en}, 0);
    end

    // Load return collides with ALU: load first, ALU deferred through skid.
    ld_issue = 1; ld_dst = 5'd3;
    cyc(); idle();
    chk("pend_r3", pend_mask, 32'h8);
    ld_rvalid = 1; ld_rdata = 32'h55; alu_valid = 1; alu_dst = 5'd4; alu_data = 32'h66;
    expw(5'd3, 32'h55); expw(5'd4, 32'h66);
    cyc(); idle();
    chk("skid_alu_ready", {31'd0, alu_ready}, 0);
    cyc();
    chk("skid_alu_ready_back", {31'd0, alu_ready}, 1);
    cyc();

    // WAW: younger ALU write kills the pending load.
    ld_issue = 1; ld_dst = 5'd8;
    cyc(); idle();
    chk("pend_r8", pend_mask, 32'h100);
    alu_valid = 1; alu_dst = 5'd8; alu_data = 32'h1;
    expw(5'd8, 32'h1);
    cyc(); idle();
    chk("pend_r8_killed", pend_mask, 0);
    cyc();
    ld_rvalid = 1; ld_rdata = 32'h99;
    cyc(); idle();
    chk("killed_ld_no_wr", {31'd0, wr_en}, 0);
    chk("killed_ld_no_err", {31'd0, ld_err}, 0);

    // Same-cycle load push and ALU to same reg: load survives and writes last.
    ld_issue = 1; ld_dst = 5'd6; alu_valid = 1; alu_dst = 5'd6; alu_data = 32'h42;
    expw(5'd6, 32'h42);
    cyc(); idle();
    chk("pend_r6_young", pend_mask, 32'h40);
    ld_rvalid = 1; ld_rdata = 32'h77;
    expw(5'd6, 32'h77);
    cyc(); idle();
    cyc();

    // Fill the tag FIFO.
    for (int i = 0; i < 4; i++) begin
      chk("fill_ld_ready", {31'd0, ld_ready}, 1);
      ld_issue = 1; ld_dst = 5'(10 + i);
      cyc();
    end
    idle();
    chk("full_ld_ready", {31'd0, ld_ready}, 0);
    chk("full_pend", pend_mask, 32'h3C00);
    // Issue while full with same-cycle pop: no push.
    ld_issue = 1; ld_dst = 5'd20; ld_rvalid = 1; ld_rdata = 32'hA0;
    expw(5'd10, 32'hA0);
    cyc(); idle();
    chk("pop_ld_ready", {31'd0, ld_ready}, 1);
    chk("pop_pend", pend_mask, 32'h3800);
    for (int i = 1; i < 4; i++) begin
      ld_rvalid = 1; ld_rdata = 32'hA0 + 32'(i);
      expw(5'(10 + i), 32'hA0 + 32'(i));
      cyc();
    end
    idle();
    chk("drain_pend", pend_mask, 0);

    // Return with empty FIFO: no write, sticky error.
    ld_rvalid = 1; ld_rdata = 32'hBAD;
    cyc(); idle();
    chk("err_no_wr", {31'd0, wr_en}, 0);
    chk("err_set", {31'd0, ld_err}, 1);
    cyc(); cyc();
    chk("err_hold", {31'd0, ld_err}, 1);
    chk("err_addr_hold", {27'd0, wr_addr}, 32'd13);

    // Reset mid-stream drops the in-flight tag.
    ld_issue = 1; ld_dst = 5'd9;
    cyc(); idle();
    chk("pre_rst_pend", pend_mask, 32'h200);
    reset = 1;
    cyc();
    reset = 0;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 0);
    chk("mid_rst_wr_addr", {27'd0, wr_addr}, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_pend", pend_mask, 0);
    chk("mid_rst_err", {31'd0, ld_err}, 0);
    ld_rvalid = 1; ld_rdata = 32'h123;
    cyc(); idle();
    chk("late_ret_err", {31'd0, ld_err}, 1);
    chk("late_ret_no_wr", {31'd0, wr_en}, 0);

    cyc(); cyc(); cyc();
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
